// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - field-level request to 18-bit ir word encoder
// Expands wide LI constants into MOV/SETHI and streams words through a one-word output register.
module insn_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_rs1,
    input  logic [3:0]  req_rs2,
    input  logic [17:0] req_imm,
    input  logic        req_immflag,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [17:0] ir,
    output logic        err,
    output logic [15:0] words
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT1,
        S_OUT2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [17:0] r_ir;
    logic [17:0] r_sethi;
    logic        r_pend;
    logic        r_err;
    logic [15:0] r_words;

    logic        w_fits9;
    logic        w_legal;
    logic        w_two;
    logic [17:0] w_word1;
    logic [17:0] w_word2;
    logic        w_accept;
    logic        w_handoff;
    logic        w_load1;
    logic        w_load2;

    assign w_fits9 = (req_imm[17:9] == {9{req_imm[8]}});

    always_comb begin
        w_legal = 1'b1;
        w_two   = 1'b0;
        w_word1 = 18'd0;
        w_word2 = {5'b11001, req_imm[17:9], req_rd};
        case (req_kind)
            4'd0: w_word1 = {3'b000, req_op, req_rs2, req_rs1, req_rd};
            4'd1: begin
                // Only SHL(0), SHR(2), SAR(3) have a 2-bit encoding.
                w_legal = (req_op == 3'd0 || req_op == 3'd2 || req_op == 3'd3)
                          && (!req_immflag || req_imm[17:4] == 14'd0);
                w_word1 = {3'b001, req_immflag, req_op[1:0],
                           req_immflag ? req_imm[3:0] : req_rs2, req_rs1, req_rd};
            end
            4'd2: begin
                w_legal = (req_imm[17:4] == 14'd0);
                w_word1 = {6'b010010, req_imm[3:0], req_rs1, req_rs2};
            end
            4'd3: begin
                w_legal = (req_imm[17:11] == 7'd0);
                w_word1 = {3'b011, req_imm[10:0], req_rs2};
            end
            4'd4: begin
                w_legal = (req_imm[17:11] == 7'd0);
                w_word1 = {3'b100, req_imm[10:0], req_rd};
            end
            4'd5: begin
                w_legal = (req_imm[17:11] == 7'd0);
                w_word1 = {3'b101, req_imm[10:0], req_rs1};
            end
            4'd6: begin
                w_word1 = {5'b11000, req_imm[8:0], req_rd};
                w_two   = !w_fits9;
            end
            4'd7: begin
                w_legal = w_fits9;
                w_word1 = {5'b11010, req_imm[8:0], req_rd};
            end
            4'd8: begin
                w_legal = w_fits9;
                w_word1 = {5'b11011, req_imm[8:0], req_rs1};
            end
            4'd9:  w_word1 = {5'b11001, req_imm[17:9], req_rd};
            4'd10: w_word1 = {6'b111110, 8'd0, req_rd};
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load1      = 1'b0;
        w_load2      = 1'b0;
        req_ready    = 1'b0;
        case (r_state)
            S_IDLE:  req_ready = 1'b1;
            S_OUT1:  req_ready = !r_pend && ir_ready;
            S_OUT2:  req_ready = ir_ready;
            default: req_ready = 1'b0;
        endcase
        w_accept  = req_valid && req_ready;
        w_handoff = (r_state != S_IDLE) && ir_ready;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_next = S_OUT1;
                    w_load1      = 1'b1;
                end
            end
            S_OUT1, S_OUT2: begin
                if (w_handoff) begin
                    if (r_state == S_OUT1 && r_pend) begin
                        w_state_next = S_OUT2;
                        w_load2      = 1'b1;
                    end else if (w_accept && w_legal) begin
                        w_state_next = S_OUT1;
                        w_load1      = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir    <= 18'd0;
            r_sethi <= 18'd0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= 16'd0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_handoff) begin
                r_words <= r_words + 16'd1;
            end
            if (w_load1) begin
                r_ir    <= w_word1;
                r_pend  <= w_two;
                r_sethi <= w_word2;
            end else if (w_load2) begin
                r_ir   <= r_sethi;
                r_pend <= 1'b0;
            end
        end
    end

    assign ir_valid = (r_state != S_IDLE);
    assign ir       = r_ir;
    assign err      = r_err;
    assign words    = r_words;

endmodule

// File: tb/tb_insn_encoder.sv
// tb/tb_insn_encoder.sv - directed and randomized checks of insn_encoder
module tb_insn_encoder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [2:0]  req_op;
    logic [3:0]  req_rd;
    logic [3:0]  req_rs1;
    logic [3:0]  req_rs2;
    logic [17:0] req_imm;
    logic        req_immflag;
    logic        ir_valid;
    logic        ir_ready;
    logic [17:0] ir;
    logic        err;
    logic [15:0] words;

    int n_cmp = 0;
    int n_fail = 0;

    insn_encoder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_op(req_op), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_immflag(req_immflag),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .err(err), .words(words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int kind, input int op, input int rd, input int rs1,
                           input int rs2, input int imm, input int immflag);
        req_valid   = 1'b1;
        req_kind    = 4'(kind);
        req_op      = 3'(op);
        req_rd      = 4'(rd);
        req_rs1     = 4'(rs1);
        req_rs2     = 4'(rs2);
        req_imm     = 18'(imm);
        req_immflag = 1'(immflag);
    endtask

    // Reference: words an accepted request should produce, built from field values.
    function automatic void ref_model(input int kind, input int op, input int rd, input int rs1,
                                      input int rs2, input int imm, input int immflag,
                                      output bit legal, output int n,
                                      output logic [17:0] w0, output logic [17:0] w1);
        int sv;
        bit fits9;
        int lo9;
        int hi9;
        int v0;
        int v1;
        sv    = (imm >= 131072) ? imm - 262144 : imm;
        fits9 = (sv >= -256) && (sv <= 255);
        lo9   = imm % 512;
        hi9   = imm / 512;
        legal = 1'b1;
        n     = 1;
        v0    = 0;
        v1    = 0;
        case (kind)
            0: v0 = op * 4096 + rs2 * 256 + rs1 * 16 + rd;
            1: begin
                legal = (op == 0 || op == 2 || op == 3) && (immflag == 0 || imm < 16);
                v0 = 32768 + immflag * 16384 + (op % 4) * 4096
                     + ((immflag != 0) ? imm % 16 : rs2) * 256 + rs1 * 16 + rd;
            end
            2: begin
                legal = imm < 16;
                v0 = 18 * 4096 + imm * 256 + rs1 * 16 + rs2;
            end
            3, 4, 5: begin
                legal = imm < 2048;
                v0 = kind * 32768 + imm * 16 + ((kind == 3) ? rs2 : (kind == 4) ? rd : rs1);
            end
            6: begin
                v0 = 24 * 8192 + lo9 * 16 + rd;
                if (!fits9) begin
                    n  = 2;
                    v1 = 25 * 8192 + hi9 * 16 + rd;
                end
            end
            7: begin
                legal = fits9;
                v0 = 26 * 8192 + lo9 * 16 + rd;
            end
            8: begin
                legal = fits9;
                v0 = 27 * 8192 + lo9 * 16 + rs1;
            end
            9:  v0 = 25 * 8192 + hi9 * 16 + rd;
            10: v0 = 62 * 4096 + rd;
            default: legal = 1'b0;
        endcase
        if (!legal) n = 0;
        w0 = 18'(v0);
        w1 = 18'(v1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp += 5;
        if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
        if (ir !== 18'd0) begin n_fail++; $display("FAIL reset_ir got %h want 0", ir); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (words !== 16'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_li_single();
        ir_ready = 1'b1;
        set_req(6, 0, 3, 0, 0, 'h00005, 0);
        tick();
        req_valid = 1'b0;
        n_cmp += 3;
        if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL li_single_valid got %b want 1", ir_valid); end
        if (ir !== 18'h30053) begin n_fail++; $display("FAIL li_single_ir got %h want 30053", ir); end
        tick();
        if (words !== 16'd1) begin n_fail++; $display("FAIL li_single_words got %0d want 1", words); end
    endtask

    task automatic test_li_pair();
        logic [15:0] base;
        base = words;
        ir_ready = 1'b1;
        set_req(6, 0, 2, 0, 0, 'h12345, 0);
        tick();
        req_valid = 1'b0;
        #1;
        n_cmp += 5;
        if (ir !== 18'h31452) begin n_fail++; $display("FAIL li_pair_mov got %h want 31452", ir); end
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL li_pair_ready got %b want 0", req_ready); end
        tick();
        if (ir !== 18'h32912 || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL li_pair_sethi got %h/%b want 32912/1", ir, ir_valid);
        end
        if (words !== base + 16'd1) begin n_fail++; $display("FAIL li_pair_words1 got %0d want %0d", words, base + 16'd1); end
        tick();
        if (words !== base + 16'd2 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL li_pair_done got %0d/%b want %0d/0", words, ir_valid, base + 16'd2);
        end
    endtask

    task automatic test_encodings();
        int kind [3] = '{6, 0, 3};
        int op   [3] = '{0, 4, 0};
        int rd   [3] = '{1, 1, 0};
        int rs1  [3] = '{0, 2, 0};
        int rs2  [3] = '{0, 3, 14};
        int imm  [3] = '{'h3FFFF, 0, 'h123};
        logic [17:0] exp [3] = '{18'h31FF1, 18'h04321, 18'h1923E};
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(kind[i], op[i], rd[i], rs1[i], rs2[i], imm[i], 0);
            tick();
            req_valid = 1'b0;
            n_cmp++;
            if (ir !== exp[i] || ir_valid !== 1'b1) begin
                n_fail++; $display("FAIL encode_%0d got %h/%b want %h/1", i, ir, ir_valid, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        int kinds [2] = '{7, 12};
        logic [15:0] base;
        ir_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            base = words;
            set_req(kinds[i], 0, 1, 1, 1, 'h00200, 0);
            tick();
            req_valid = 1'b0;
            n_cmp += 2;
            if (err !== 1'b1 || ir_valid !== 1'b0) begin
                n_fail++; $display("FAIL illegal_%0d_pulse err=%b valid=%b want 1/0", kinds[i], err, ir_valid);
            end
            tick();
            if (err !== 1'b0 || ir_valid !== 1'b0 || words !== base) begin
                n_fail++; $display("FAIL illegal_%0d_after err=%b valid=%b words=%0d want 0/0/%0d",
                                   kinds[i], err, ir_valid, words, base);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        base = words;
        ir_ready = 1'b0;
        set_req(0, 4, 1, 2, 3, 0, 0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ir !== 18'h04321 || ir_valid !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_%0d ir=%h valid=%b ready=%b want 04321/1/0",
                                   i, ir, ir_valid, req_ready);
            end
            tick();
        end
        ir_ready = 1'b1;
        set_req(3, 0, 0, 0, 14, 'h123, 0);
        #1;
        n_cmp += 3;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        if (ir !== 18'h1923E || words !== base + 16'd1) begin
            n_fail++; $display("FAIL b2b_next ir=%h words=%0d want 1923e/%0d", ir, words, base + 16'd1);
        end
        tick();
        if (ir_valid !== 1'b0 || words !== base + 16'd2) begin
            n_fail++; $display("FAIL b2b_done valid=%b words=%0d want 0/%0d", ir_valid, words, base + 16'd2);
        end
    endtask

    task automatic test_reset_out2();
        ir_ready = 1'b1;
        set_req(6, 0, 2, 0, 0, 'h12345, 0);
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp += 3;
        if (ir !== 18'h32912) begin n_fail++; $display("FAIL rst_out2_setup got %h want 32912", ir); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (ir_valid !== 1'b0 || words !== 16'd0) begin
            n_fail++; $display("FAIL rst_out2 valid=%b words=%0d want 0/0", ir_valid, words);
        end
        for (int i = 0; i < 3; i++) tick();
        if (ir_valid !== 1'b0 || words !== 16'd0) begin
            n_fail++; $display("FAIL rst_out2_later valid=%b words=%0d want 0/0", ir_valid, words);
        end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] w0;
        logic [17:0] w1;
        bit          legal;
        bit          exp_err;
        bit          exp_ready;
        bit          acc;
        bit          ho;
        bit          have_req;
        int          n;
        int          wexp;
        int          k, o, d, s1, s2, im, fl;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wexp = 0;
        exp_err = 1'b0;
        have_req = 1'b0;
        k = 0; o = 0; d = 0; s1 = 0; s2 = 0; im = 0; fl = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!have_req) begin
                k  = $urandom_range(0, 15);
                o  = (k == 1) ? $urandom_range(0, 3) : $urandom_range(0, 7);
                d  = $urandom_range(0, 15);
                s1 = $urandom_range(0, 15);
                s2 = $urandom_range(0, 15);
                fl = $urandom_range(0, 1);
                case ($urandom_range(0, 3))
                    0: im = $urandom_range(0, 262143);
                    1: im = $urandom_range(0, 2047);
                    2: im = 262144 - $urandom_range(1, 300);
                    default: im = $urandom_range(0, 15);
                endcase
                have_req = ($urandom_range(0, 3) != 0);
            end
            set_req(k, o, d, s1, s2, im, fl);
            req_valid = have_req;
            ir_ready  = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (q.size() == 0) ? 1'b1 : (q.size() == 1) ? ir_ready : 1'b0;
            n_cmp += 2;
            if (ir_valid !== (q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, ir_valid, q.size() > 0);
            end
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, req_ready, exp_ready);
            end
            if (q.size() > 0) begin
                n_cmp++;
                if (ir !== q[0]) begin n_fail++; $display("FAIL rnd_ir cyc %0d got %h want %h", cyc, ir, q[0]); end
            end
            acc = have_req && exp_ready;
            ho  = (q.size() > 0) && ir_ready;
            @(posedge clk);
            if (ho) begin
                void'(q.pop_front());
                wexp++;
            end
            exp_err = 1'b0;
            if (acc) begin
                ref_model(k, o, d, s1, s2, im, fl, legal, n, w0, w1);
                exp_err = !legal;
                if (n >= 1) q.push_back(w0);
                if (n == 2) q.push_back(w1);
                have_req = 1'b0;
            end
            #2;
            n_cmp += 2;
            if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, err, exp_err); end
            if (words !== 16'(wexp)) begin
                n_fail++; $display("FAIL rnd_words cyc %0d got %0d want %0d", cyc, words, wexp);
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_kind = '0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_imm = '0; req_immflag = 1'b0;
        ir_ready = 1'b0;
        test_reset();
        test_li_single();
        test_li_pair();
        test_encodings();
        test_illegal();
        test_back_to_back();
        test_reset_out2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

Encoder for the 18-bit instruction word. It takes field-level instruction requests from the debug/monitor injector and emits legal `ir` words through a valid/ready stream into the instruction path that feeds the decoder. Load-immediate requests whose constant does not fit in 9 signed bits are expanded into a MOV/SETHI pair. The block holds a one-word output register and drives a small state machine for two-word sequences.

## Interface
- No parameters.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on the edge where `req_valid && req_ready`.
- `req_kind` in 4: 0 ALU, 1 SHIFT, 2 STB, 3 JCC, 4 CALL, 5 JR, 6 LI, 7 ADDI, 8 CMPI, 9 SETHI, 10 KBD; 11–15 illegal.
- `req_op` in 3: ALU op (0–7) or shift op (0 SHL, 2 SHR, 3 SAR; 1 illegal).
- `req_rd` in 4: destination register.
- `req_rs1` in 4: source 1 / STB base / JR target register.
- `req_rs2` in 4: source 2 / STB data register / JCC condition.
- `req_imm` in 18: immediate.
- `req_immflag` in 1: SHIFT only; 1 selects the 4-bit immediate count instead of `rs2`.
- `ir_valid` out 1: output word present.
- `ir_ready` in 1: consumer accepts on the edge where `ir_valid && ir_ready`.
- `ir` out 18: encoded word.
- `err` out 1: one-cycle pulse when an accepted request is illegal.
- `words` out 16: count of words handed off; wraps modulo 2^16.

## Operation
Encodings (bit ranges of `ir`):
- ALU: [17:15]=000, [14:12]=op, [11:8]=rs2, [7:4]=rs1, [3:0]=rd.
- SHIFT: [17:15]=001, [14]=immflag, [13:12]=op, [11:8]=imm[3:0] if immflag else rs2, [7:4]=rs1, [3:0]=rd.
- STB: [17:12]=010010, [11:8]=imm[3:0], [7:4]=rs1, [3:0]=rs2.
- JCC: [17:15]=011, [14:4]=imm[10:0], [3:0]=cond. CALL: 100, [3:0]=rd. JR: 101, [3:0]=rs1. Field layout is otherwise the same as JCC.
- MOV/SETHI/ADDI/CMPI: [17:13]=11000/11001/11010/11011, [12:4]=imm9, [3:0]=rd (rs1 for CMPI).
- KBD: [17:12]=111110, [11:4]=0, [3:0]=rd.

Legality (an illegal request is consumed, `err` pulses, and no word is emitted):
- SHIFT immflag=1 or STB: imm[17:4] must be 0.
- JCC/CALL/JR: imm[17:11] must be 0.
- ADDI/CMPI: imm[17:9] must all equal imm[8].
- SETHI: the word carries imm[17:9], and imm[8:0] is ignored.
- Shift op 1 is illegal. Kinds 11–15 are illegal.

LI expansion:
- If imm[17:9] all equal imm[8], emit one MOV rd, imm[8:0].
- Otherwise emit MOV rd, imm[8:0], then SETHI rd, imm[17:9]. SETHI keeps the low 9 bits of rd, so the result equals the full imm.

States:
- IDLE: `ir_valid`=0. On accept, go to OUT1 with the first word, or stay in IDLE and pulse `err` if the request is illegal.
- OUT1: `ir_valid`=1. On handoff:
  - If a SETHI is pending, load it into `ir` and go to OUT2.
  - Otherwise return to IDLE, or go directly to OUT1 again if a new request is accepted on the same edge.
- OUT2: `ir_valid`=1. On handoff, behaves like OUT1 with no pending word.

`req_ready` (combinational): 1 in IDLE; in OUT1 with no pending word, or in OUT2, equals `ir_ready`; otherwise 0.

`words` increments on every handoff.

## Timing
- Reset values: state IDLE, `ir_valid`=0, `ir`=0, `err`=0, `words`=0, pending cleared. `req_ready` is therefore 1 after reset.
- Latency:
  - Request accepted at edge T gives `ir_valid`=1 with the first word from T+1.
  - For an illegal request, `err`=1 during cycle T+1 only.
- Throughput: one word per cycle under continuous `ir_ready`. A two-word LI blocks `req_ready` for one cycle.
- `ir` is stable while `ir_valid && !ir_ready`.
- Reset asserted in any state, including OUT2, discards the pending or presented words. It has priority over a simultaneous handoff or accept, and `words` does not count that handoff.

## Test plan
- LI rd=3, imm=0x00005 -> single word 0x30053, `words`=1.
- LI rd=2, imm=0x12345 -> 0x31452 then 0x32912 on consecutive cycles with `ir_ready`=1. `req_ready`=0 in the cycle 0x31452 is presented.
- LI rd=1, imm=0x3FFFF -> single 0x31FF1. ALU op=4, rd=1, rs1=2, rs2=3 -> 0x04321. JCC cond=0xE, imm=0x123 -> 0x1923E.
- ADDI imm=0x00200 -> `err` for one cycle, `ir_valid` stays 0, `words` unchanged. Kind 12 -> same response.
- Hold `ir_ready`=0 for 3 cycles after an ALU request -> `ir` stays constant, `req_ready`=0. Release -> exactly one handoff, and a back-to-back request is accepted on the same edge.
- LI 0x12345 with `rst` asserted while the SETHI word 0x32912 is presented -> `ir_valid`=0, `words`=0 next cycle, and no SETHI ever handed off.
